// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Queue entries carry a 32-bit PC; fetch_unit supports ADDR_W up to 32.
package fetch_pkg;

  localparam int unsigned PC_W             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch stage, instruction memory and decode.
// The master side is the fetch unit.
interface fetch_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] instr_pc4;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr, instr_pc, instr_pc4
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr, instr_pc, instr_pc4
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {instr, pc} entries; pointers wrap at DEPTH.
// flush empties the queue on the next edge regardless of push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle imem reads, buffers the
// returned words and hands them to decode; redirects flush all older fetches.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_if.master           bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic              drop;
  logic              handshake;
  logic              pop;
  logic              push;
  logic              issue;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      push_data;
  logic [ADDR_W-1:0] head_pc;

  assign handshake = bus.instr_valid && bus.instr_ready;
  // A redirect flushes the head, so that handshake is not a real consume.
  assign pop       = handshake && !redirect;

  // Occupancy counts the queued entries plus the response due this cycle.
  always_comb begin
    issue = 1'b0;
    if (state == RUN && !redirect)
      issue = (32'(count) + 32'(inflight) - 32'(handshake)) < DEPTH;
  end

  assign push = inflight && !drop && !redirect && (!full || pop);

  always_comb begin
    push_data       = '0;
    push_data.instr = bus.imem_rdata;
    push_data.pc    = PC_W'(req_pc);
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= issue;
      drop     <= redirect && inflight;
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        req_pc   <= fetch_pc;
      end
      if (redirect)
        fetch_pc <= redirect_pc & ~ADDR_W'(3);

      case (state)
        IDLE:    if (fetch_en) state <= RUN;
        RUN:     if (!fetch_en) state <= DRAIN;
        DRAIN: begin
          if (fetch_en)                state <= RUN;
          else if (empty && !inflight) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign head_pc         = empty ? '0 : ADDR_W'(head.pc);
  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = !empty;
  assign bus.instr       = empty ? '0 : head.instr;
  assign bus.instr_pc    = head_pc;
  assign bus.instr_pc4   = head_pc + ADDR_W'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations (boot, backpressure, redirects, wrap, drain).
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int unsigned AW      = 32;
  localparam int unsigned DEPTH   = 2;
  localparam logic [31:0] BOOT_PC = 32'hBFC0_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  int          total = 0;
  int          bad   = 0;
  int          n;
  int          k;

  fetch_if #(.ADDR_W(AW)) bus ();
  fetch_if #(.ADDR_W(AW)) wbus ();

  fetch_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(BOOT_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  fetch_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) wdut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (1'b1),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .bus         (wbus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Synchronous memories: data appears the cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    bus.imem_rdata  <= bus.imem_req  ? word_at(bus.imem_addr)  : 32'hBAD0_BAD0;
    wbus.imem_rdata <= wbus.imem_req ? word_at(wbus.imem_addr) : 32'hBAD0_BAD0;
  end
  assign wbus.instr_ready = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: fetched words as an ordered list, with one outstanding read at most.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  ent_t        e;
  int          mst   = 0;          // 0 idle, 1 running, 2 draining
  logic [31:0] mpc   = BOOT_PC;
  logic [31:0] mipc  = '0;
  bit          minf  = 1'b0;
  bit          mdrop = 1'b0;
  bit          started = 1'b0;
  bit          ev, ep, er, mpush;
  int          occ;

  always @(posedge clk) if (!rst_n) started <= 1'b1;

  always @(negedge clk) if (started) begin
    ev = (mq.size() != 0);
    check("valid", 32'(bus.instr_valid), 32'(ev));
    if (ev) begin
      check("instr", bus.instr, mq[0].instr);
      check("pc", bus.instr_pc, mq[0].pc);
      check("pc4", bus.instr_pc4, mq[0].pc + 32'd4);
    end
    ep  = ev && bus.instr_ready;
    occ = mq.size() + (minf ? 1 : 0) - (ep ? 1 : 0);
    er  = (mst == 1) && !redirect && (occ < int'(DEPTH));
    check("req", 32'(bus.imem_req), 32'(er));
    if (er) check("addr", bus.imem_addr, mpc);

    if (!rst_n) begin
      mq.delete();
      mst = 0; mpc = BOOT_PC; minf = 1'b0; mdrop = 1'b0;
    end else begin
      mpush = minf && !mdrop && !redirect;
      case (mst)
        0:       if (fetch_en) mst = 1;
        1:       if (!fetch_en) mst = 2;
        default: if (fetch_en) mst = 1;
                 else if (mq.size() == 0 && !minf) mst = 0;
      endcase
      if (redirect) begin
        mq.delete();
        mpc   = redirect_pc & ~32'd3;
        mdrop = minf;
        minf  = 1'b0;
      end else begin
        if (ep) void'(mq.pop_front());
        if (mpush) begin
          e.instr = word_at(mipc);
          e.pc    = mipc;
          mq.push_back(e);
        end
        mdrop = 1'b0;
        if (er) begin
          minf = 1'b1; mipc = mpc; mpc = mpc + 32'd4;
        end else begin
          minf = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.instr_ready = 1'b0;
    repeat (3) cyc();
    #1;
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_pc", bus.instr_pc, 32'd0);
    check("wrap_rst_valid", 32'(wbus.instr_valid), 32'd0);

    // Boot: one idle cycle, then a request every cycle, 2-cycle latency to decode.
    cyc(); rst_n = 1'b1; fetch_en = 1'b1; bus.instr_ready = 1'b1;
    #1; check("boot_idle_req", 32'(bus.imem_req), 32'd0);
    cyc(); #1;
    check("boot_req", 32'(bus.imem_req), 32'd1);
    check("boot_addr", bus.imem_addr, 32'hBFC0_0000);
    check("wrap_addr0", wbus.imem_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    check("boot_c1_valid", 32'(bus.instr_valid), 32'd0);
    check("boot_c1_addr", bus.imem_addr, 32'hBFC0_0004);
    check("wrap_addr1", wbus.imem_addr, 32'h0000_0000);
    cyc(); #1;
    check("boot_c2_valid", 32'(bus.instr_valid), 32'd1);
    check("boot_c2_pc", bus.instr_pc, 32'hBFC0_0000);
    check("boot_c2_pc4", bus.instr_pc4, 32'hBFC0_0004);
    check("boot_c2_instr", bus.instr, 32'h616D_0000);
    check("wrap_pc0", wbus.instr_pc, 32'hFFFF_FFFC);
    check("wrap_pc4_0", wbus.instr_pc4, 32'h0000_0000);
    check("wrap_instr0", wbus.instr, 32'h2152_FFFC);
    cyc(); #1;
    check("boot_c3_pc", bus.instr_pc, 32'hBFC0_0004);
    check("wrap_pc1", wbus.instr_pc, 32'h0000_0000);
    check("wrap_pc4_1", wbus.instr_pc4, 32'h0000_0004);
    repeat (4) cyc();

    // Backpressure from boot: two entries buffered, requests stop, nothing lost.
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1; bus.instr_ready = 1'b0;
    cyc();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.imem_req) n++;
      cyc();
    end
    #1;
    check("bp_req_count", 32'(n), 32'd2);
    check("bp_valid", 32'(bus.instr_valid), 32'd1);
    check("bp_head_pc", bus.instr_pc, 32'hBFC0_0000);
    bus.instr_ready = 1'b1;
    cyc(); #1; check("bp_pc1", bus.instr_pc, 32'hBFC0_0004);
    cyc(); #1; check("bp_pc2", bus.instr_pc, 32'hBFC0_0008);
    repeat (3) cyc();

    // Redirect while a read is outstanding: its word is dropped.
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    #1; check("rd_req_blocked", 32'(bus.imem_req), 32'd0);
    cyc(); redirect = 1'b0;
    #1;
    check("rd_flushed", 32'(bus.instr_valid), 32'd0);
    check("rd_new_addr", bus.imem_addr, 32'h0000_0100);
    cyc(); #1; check("rd_gap", 32'(bus.instr_valid), 32'd0);
    cyc(); #1;
    check("rd_new_pc", bus.instr_pc, 32'h0000_0100);
    check("rd_new_instr", bus.instr, 32'hDEAD_0100);
    repeat (2) cyc();

    // Full queue, redirect and a pop in the same cycle.
    bus.instr_ready = 1'b0;
    repeat (4) cyc();
    bus.instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    #1; check("fr_full_valid", 32'(bus.instr_valid), 32'd1);
    cyc(); redirect = 1'b0;
    #1;
    check("fr_empty", 32'(bus.instr_valid), 32'd0);
    check("fr_addr", bus.imem_addr, 32'h0000_0200);
    cyc(); cyc(); #1;
    check("fr_pc", bus.instr_pc, 32'h0000_0200);

    // Back-to-back redirects: the second target wins.
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_0300;
    cyc(); redirect_pc = 32'h0000_0403;
    cyc(); redirect = 1'b0;
    #1;
    check("b2b_addr", bus.imem_addr, 32'h0000_0400);
    check("b2b_empty", 32'(bus.instr_valid), 32'd0);
    cyc(); cyc(); #1;
    check("b2b_pc", bus.instr_pc, 32'h0000_0400);
    check("b2b_instr", bus.instr, 32'hDEAD_0400);
    repeat (2) cyc();

    // Stop fetching mid-stream: queue drains, then no more requests.
    fetch_en = 1'b0;
    #1;
    k = 0;
    while (bus.instr_valid && k < 10) begin
      cyc(); #1;
      k++;
    end
    check("drain_empty", 32'(bus.instr_valid), 32'd0);
    cyc(); #1; check("drain_idle_req", 32'(bus.imem_req), 32'd0);
    cyc(); #1; check("drain_idle_req2", 32'(bus.imem_req), 32'd0);

    // Reset while draining a non-empty queue.
    fetch_en = 1'b1; bus.instr_ready = 1'b0;
    repeat (5) cyc();
    fetch_en = 1'b0;
    cyc(); cyc(); #1;
    check("dr_full_valid", 32'(bus.instr_valid), 32'd1);
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    #1;
    check("dr_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("dr_rst_pc", bus.instr_pc, 32'd0);
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
